// File: rtl/cla_seq_adder_pkg.sv
// Shared constants and FSM encoding for the slice-serial CLA adder.
package cla_seq_adder_pkg;
   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/cla_seq_adder_cla.sv
// 4-bit carry-lookahead adder: one slice of the sequential wide adder.
module cla_adder
   import cla_seq_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] A,
   input  logic [SLICE_W-1:0] B,
   input  logic               Cin,
   output logic [SLICE_W-1:0] Sum,
   output logic               Carry
);
   logic [SLICE_W-1:0] g, p;
   logic [SLICE_W:0]   c;

   assign g = A & B;
   assign p = A ^ B;

   // Flattened lookahead equations; no internal ripple.
   assign c[0] = Cin;
   assign c[1] = g[0] | (p[0] & Cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & Cin);

   assign Sum   = p ^ c[SLICE_W-1:0];
   assign Carry = c[SLICE_W];
endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA, one slice per clock, LSB first,
// with valid/ready handshakes on operand and result sides.
module cla_seq_adder
   import cla_seq_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry,
   output logic             Overflow
);
   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   generate
      if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
         $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t             state;
   logic [WIDTH-1:0]   a_r, b_r;
   logic               cy;
   logic [IDX_W-1:0]   idx;

   logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
   logic               sl_co, msb_cin, last;

   assign sl_a = a_r[idx*SLICE_W +: SLICE_W];
   assign sl_b = b_r[idx*SLICE_W +: SLICE_W];
   assign last = (idx == IDX_W'(NSLICE-1));
   // Carry into bit 3 of the slice, recovered from the sum bit.
   assign msb_cin = sl_sum[SLICE_W-1] ^ sl_a[SLICE_W-1] ^ sl_b[SLICE_W-1];

   cla_adder u_cla (
      .A     (sl_a),
      .B     (sl_b),
      .Cin   (cy),
      .Sum   (sl_sum),
      .Carry (sl_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Sum       <= '0;
         Carry     <= 1'b0;
         Overflow  <= 1'b0;
         idx       <= '0;
         cy        <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_r      <= A;
                  b_r      <= B;
                  cy       <= Cin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               Sum[idx*SLICE_W +: SLICE_W] <= sl_sum;
               cy <= sl_co;
               if (last) begin
                  Carry     <= sl_co;
                  Overflow  <= msb_cin ^ sl_co;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed-vector bench for cla_seq_adder at WIDTH=16.
module tb_cla_seq_adder;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [15:0] A, B;
   logic        Cin;
   logic        out_valid, out_ready;
   logic [15:0] Sum;
   logic        Carry, Overflow;

   int n_pass = 0;
   int n_chk  = 0;

   cla_seq_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
      .Sum(Sum), .Carry(Carry), .Overflow(Overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present operands for one accept edge; returns after that edge.
   task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic c);
      int n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; A = a; B = b; Cin = c;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk({tag, "_lat"}, n, 4);
   endtask

   task automatic check_result(input string tag, input logic [15:0] s, input logic c, input logic v);
      chk({tag, "_sum"}, {16'd0, Sum}, {16'd0, s});
      chk({tag, "_carry"}, {31'd0, Carry}, {31'd0, c});
      chk({tag, "_ovf"}, {31'd0, Overflow}, {31'd0, v});
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_ir_rise"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic vec(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] s, input logic co, input logic v);
      accept(a, b, c);
      wait_result(tag);
      check_result(tag, s, co, v);
      drain(tag);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_result("rst", 16'h0000, 1'b0, 1'b0);

      // out_ready held high through CALC must not shortcut the result
      out_ready = 1'b1;
      accept(16'h5A5A, 16'hA5A5, 1'b0);
      wait_result("v1");
      check_result("v1", 16'hFFFF, 1'b0, 1'b0);
      drain("v1");

      vec("v2", 16'h5A5A, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0);
      vec("v3", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      vec("v4", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      vec("v5", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Backpressure with an intruding request
      accept(16'h0F0F, 16'h0101, 1'b0);
      wait_result("bp");
      in_valid = 1'b1; A = 16'h1111; B = 16'h1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
         check_result("bp_hold", 16'h1010, 1'b0, 1'b0);
      end
      in_valid = 1'b0;
      drain("bp");

      // Reset on the second CALC cycle
      accept(16'h1234, 16'h4321, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_result("mid_rst", 16'h0000, 1'b0, 1'b0);
      vec("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      // Operands change right after accept; result uses latched values
      accept(16'h1000, 16'h2000, 1'b0);
      A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
      wait_result("iso");
      check_result("iso", 16'h3000, 1'b0, 1'b0);
      drain("iso");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
